clk_tick_gen: RTL and testbench
===============================

Name: clk_tick_gen

Overview:
- Multi-channel, parametrised clock-enable and divided-clock generator running on CLOCK_50.
- Each channel has a runtime-loadable divisor, an enable, and a continuous or one-shot mode.
- Each channel produces a 1-cycle tick strobe and a 50%-duty toggled divided clock.
- Feeds slow-rate logic in the pipeline (UART baud timing, debug stepping) with clean synchronous enables instead of derived clocks.

Parameters:
- NUM_CH, 2: number of independent channels.
- CH_W, 1: width of the channel-select field; NUM_CH <= 2**CH_W.
- CNT_W, 10: width of the counter and divisor registers.
- DEFAULT_DIV, 217: divisor loaded at reset; tick period 218 cycles.

Ports:
- CLOCK_50, input, 1: system clock; all state is updated on its rising edge.
- reset, input, 1: synchronous, active-high.
- en, input, NUM_CH: per-channel run enable.
- cfg_we, input, 1: configuration write strobe, 1 cycle.
- cfg_ch, input, CH_W: channel selected by cfg_we.
- cfg_div, input, CNT_W: new divisor.
- cfg_oneshot, input, 1: 1 = one-shot mode, 0 = continuous.
- tick, output, NUM_CH: registered 1-cycle strobe per terminal count.
- div_clk, output, NUM_CH: registered toggle output per terminal count.
- done, output, NUM_CH: one-shot completed; level signal.

Behaviour:
- Reset (reset=1 at clock edge), every channel:
  - cnt=0, div=DEFAULT_DIV, oneshot=0, state IDLE.
  - tick=0, div_clk=0, done=0.
  - Reset overrides cfg_we and en. Reset mid-count discards all progress.
- Per-channel states: IDLE, RUN, DONE.
- IDLE:
  - Counter held, tick=0, div_clk held.
  - en=1 moves to RUN next cycle; cnt keeps its held value (resume, not restart).
- RUN, en=1:
  - If cnt==div: cnt<=0, tick<=1 for exactly one cycle, div_clk<=~div_clk.
  - Otherwise cnt<=cnt+1, tick<=0.
  - Tick period = div+1 cycles; div_clk period = 2*(div+1) cycles.
  - Unsigned arithmetic; cnt never exceeds div.
- RUN, en=0: go to IDLE, cnt held, tick<=0.
- One-shot mode, RUN at terminal count: tick and div_clk update as normal, cnt<=0, state<=DONE, done<=1.
- DONE:
  - Counter stopped, tick=0, done=1.
  - Leaves DONE only on a cfg_we to this channel or on reset.
  - en has no effect in DONE.
- Configuration write (cfg_we=1, cfg_ch<NUM_CH), applied to channel cfg_ch at the clock edge:
  - div<=cfg_div, oneshot<=cfg_oneshot, cnt<=0, done<=0, tick<=0.
  - Next state is RUN if en[cfg_ch]=1, else IDLE.
  - div_clk is not changed.
  - Other channels are unaffected.
- cfg_we with cfg_ch>=NUM_CH: ignored, no state change anywhere.
- cfg_we in the same cycle as a terminal count on that channel: the write wins. No tick, no div_clk toggle, cnt<=0.
- div=0: in continuous mode tick is held 1 every RUN cycle and div_clk toggles every cycle. In one-shot mode there is a single tick one cycle after entering RUN.
- Latency: tick rises on the clock edge where cnt==div was sampled. For a fresh write with en=1, the first tick appears div+1 cycles after the write edge.
- Channels are fully independent; simultaneous terminal counts on several channels all tick in the same cycle.

Test Plan:
- Continuous period after reset: en=1 on ch0, default div 217 -> first tick 218 cycles after en is sampled, then every 218 cycles; div_clk period 436 cycles; done=0.
- Reconfigure and one-shot: write ch1 div=3, oneshot=0, en=1 -> tick every 4 cycles. Then write div=5, oneshot=1 -> exactly one tick 6 cycles later, done=1, no further ticks for 50 cycles even with en=1. A new write clears done and restarts.
- Pause/resume and div=0: write ch0 div=9, en=1 for 6 cycles, en=0 for 20 cycles, en=1 -> next tick 4 cycles after resume; no tick while paused. Then write div=0 -> tick high continuously, div_clk toggles every cycle.
- Write/terminal collision: write ch0 div=4 on the exact cycle cnt==div -> no tick that cycle; next tick 5 cycles later.
- Invalid channel write: with NUM_CH=3, CH_W=2, write cfg_ch=3 -> all channels unchanged.
- Reset mid-operation: assert reset while ch0 is mid-count and ch1 is DONE -> next cycle all outputs 0, div=217, state IDLE. After reset drops with en=1, first tick 218 cycles later.

Source files
------------

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: multi-channel clock-enable / divided-clock generator.
//
// Each channel counts CLOCK_50 cycles up to a runtime-loadable divisor and
// produces a one-cycle tick at terminal count plus a 50%-duty divided clock
// that toggles on every tick. A channel runs either continuously or one-shot.
// Slow-rate logic consumes the tick as a synchronous enable. It does not need
// a derived clock.
//
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   reset        in   synchronous, active-high
//   en           in   [NUM_CH] per-channel run enable
//   cfg_we       in   one-cycle configuration write strobe
//   cfg_ch       in   [CH_W] channel targeted by cfg_we
//   cfg_div      in   [CNT_W] new divisor (tick period = div+1)
//   cfg_oneshot  in   1 = one-shot, 0 = continuous
//   tick         out  [NUM_CH] registered one-cycle strobe at terminal count
//   div_clk      out  [NUM_CH] registered toggle on each terminal count
//   done         out  [NUM_CH] one-shot has completed (level)

module clk_tick_ch #(
    parameter int CNT_W       = 10,
    parameter int DEFAULT_DIV = 217
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_oneshot,
    output logic             tick,
    output logic             div_clk,
    output logic             done
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic             oneshot;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            div     <= DIV_RST;
            oneshot <= 1'b0;
            tick    <= 1'b0;
            div_clk <= 1'b0;
            done    <= 1'b0;
        end else if (wr) begin
            // A write beats a coincident terminal count: no tick, no toggle.
            div     <= cfg_div;
            oneshot <= cfg_oneshot;
            cnt     <= '0;
            done    <= 1'b0;
            tick    <= 1'b0;
            state   <= en ? RUN : IDLE;
        end else begin
            tick <= 1'b0;
            case (state)
                IDLE: begin
                    // Counter is held, so a later RUN resumes where it left off.
                    if (en) state <= RUN;
                end
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (cnt == div) begin
                        cnt     <= '0;
                        tick    <= 1'b1;
                        div_clk <= ~div_clk;
                        if (oneshot) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Parked until a write to this channel or a reset.
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

module clk_tick_gen #(
    parameter int NUM_CH      = 2,
    parameter int CH_W        = 1,
    parameter int CNT_W       = 10,
    parameter int DEFAULT_DIV = 217
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_oneshot,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_clk,
    output logic [NUM_CH-1:0] done
);

    // A cfg_ch value with no matching channel decodes to no write strobe.
    // Such a write is therefore dropped and changes no state.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;
        assign wr = cfg_we && (cfg_ch == CH_W'(i));

        clk_tick_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .CLOCK_50    (CLOCK_50),
            .reset       (reset),
            .en          (en[i]),
            .wr          (wr),
            .cfg_div     (cfg_div),
            .cfg_oneshot (cfg_oneshot),
            .tick        (tick[i]),
            .div_clk     (div_clk[i]),
            .done        (done[i])
        );
    end

endmodule

// File: tb/tb_clk_tick_gen.sv
// tb_clk_tick_gen: directed self-checking bench for clk_tick_gen.
// The DUT is built with three channels so that an out-of-range channel
// select (cfg_ch = 3) exists. Inputs change 1 time unit after a rising edge.
// Outputs are sampled at the same point.

module tb_clk_tick_gen;

    localparam int NUM_CH = 3;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 10;

    logic              CLOCK_50 = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] en;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_oneshot;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] div_clk;
    logic [NUM_CH-1:0] done;

    int n_tests = 0;
    int n_fail  = 0;

    clk_tick_gen #(
        .NUM_CH      (NUM_CH),
        .CH_W        (CH_W),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (217)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_oneshot (cfg_oneshot),
        .tick        (tick),
        .div_clk     (div_clk),
        .done        (done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Edges advanced until tick[ch] is seen high; -1 if the bound expires.
    task automatic wait_tick(input int ch, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (tick[ch]) begin
                n = i;
                break;
            end
        end
    endtask

    // Issues one write and advances past the write edge.
    task automatic cfg_write(input int ch, input int dv, input logic os);
        cfg_we      = 1'b1;
        cfg_ch      = CH_W'(ch);
        cfg_div     = CNT_W'(dv);
        cfg_oneshot = os;
        step();
        cfg_we      = 1'b0;
    endtask

    initial begin
        int n;
        int cnt_t;
        logic exp_dc0;

        reset = 1'b1; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_oneshot = 1'b0;
        step(); step();

        // Reset state
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_divclk", 32'(div_clk), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Continuous, default divisor 217 -> tick every 218 cycles
        en = 3'b001;
        step();                                   // en sampled: IDLE -> RUN
        chk("def_no_early_tick", 32'(tick), 32'd0);
        wait_tick(0, 300, n);
        chk("def_first_tick", 32'(n), 32'd218);
        chk("def_divclk_rise", 32'(div_clk[0]), 32'd1);
        chk("def_done", 32'(done), 32'd0);
        chk("def_other_ch_quiet", 32'(tick[2:1]), 32'd0);
        step();
        chk("def_pulse_width", 32'(tick[0]), 32'd0);
        wait_tick(0, 300, n);
        chk("def_period", 32'(n + 1), 32'd218);
        chk("def_divclk_fall", 32'(div_clk[0]), 32'd0);

        // ch1 continuous div=3 -> period 4
        en = 3'b011;
        cfg_write(1, 3, 1'b0);
        wait_tick(1, 20, n);
        chk("ch1_first_tick", 32'(n), 32'd4);
        wait_tick(1, 20, n);
        chk("ch1_period", 32'(n), 32'd4);

        // ch1 one-shot div=5 -> one tick after 6 cycles, then parked
        cfg_write(1, 5, 1'b1);
        wait_tick(1, 20, n);
        chk("os_tick", 32'(n), 32'd6);
        chk("os_done_set", 32'(done[1]), 32'd1);
        cnt_t = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (tick[1]) cnt_t++;
        end
        chk("os_no_more_ticks", 32'(cnt_t), 32'd0);
        chk("os_done_level", 32'(done[1]), 32'd1);
        cfg_write(1, 3, 1'b0);
        chk("os_done_cleared", 32'(done[1]), 32'd0);
        wait_tick(1, 20, n);
        chk("os_restart_tick", 32'(n), 32'd4);

        // ch0 pause/resume with div=9
        cfg_write(0, 9, 1'b0);
        for (int i = 0; i < 6; i++) step();     // cnt reaches 6
        en = 3'b010;
        cnt_t = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick[0]) cnt_t++;
        end
        chk("pause_no_tick", 32'(cnt_t), 32'd0);
        en = 3'b011;
        step();                                   // resume edge
        wait_tick(0, 20, n);
        chk("resume_tick", 32'(n), 32'd4);
        chk("resume_divclk", 32'(div_clk[0]), 32'd1);

        // ch0 div=0 -> tick held, div_clk toggles every cycle
        exp_dc0 = 1'b1;
        cfg_write(0, 0, 1'b0);
        chk("div0_write_no_tick", 32'(tick[0]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            exp_dc0 = ~exp_dc0;
            chk("div0_tick_held", 32'(tick[0]), 32'd1);
            chk("div0_divclk", 32'(div_clk[0]), 32'(exp_dc0));
        end

        // Write on the exact terminal-count cycle
        cfg_write(0, 6, 1'b0);
        for (int i = 0; i < 6; i++) step();     // cnt == 6 == div now
        cfg_write(0, 4, 1'b0);
        chk("coll_no_tick", 32'(tick[0]), 32'd0);
        chk("coll_divclk_kept", 32'(div_clk[0]), 32'(exp_dc0));
        wait_tick(0, 20, n);
        chk("coll_next_tick", 32'(n), 32'd5);
        exp_dc0 = ~exp_dc0;
        chk("coll_divclk_toggle", 32'(div_clk[0]), 32'(exp_dc0));

        // Write to non-existent channel 3 changes nothing
        cfg_write(3, 1, 1'b1);
        wait_tick(0, 20, n);
        chk("inv_ch0_unchanged", 32'(n), 32'd4);
        wait_tick(1, 20, n);
        wait_tick(1, 20, n);
        chk("inv_ch1_unchanged", 32'(n), 32'd4);
        chk("inv_ch2_quiet", 32'(tick[2]), 32'd0);
        chk("inv_done", 32'(done), 32'd0);

        // Reset with ch0 mid-count and ch1 in DONE
        cfg_write(1, 2, 1'b1);
        wait_tick(1, 20, n);
        chk("pre_rst_os_tick", 32'(n), 32'd3);
        chk("pre_rst_done", 32'(done[1]), 32'd1);
        step(); step();
        reset = 1'b1;
        step();
        chk("mid_rst_tick", 32'(tick), 32'd0);
        chk("mid_rst_divclk", 32'(div_clk), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        step();                                   // en=1 ignored under reset
        chk("rst_over_en_tick", 32'(tick), 32'd0);
        reset = 1'b0;
        step();                                   // en sampled: IDLE -> RUN
        wait_tick(0, 300, n);
        chk("post_rst_tick", 32'(n), 32'd218);
        chk("post_rst_sim_tick", 32'(tick), 32'd3);
        chk("post_rst_divclk", 32'(div_clk), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
